// File: rtl/nios_system_rst_out.sv
// Avalon-MM output PIO for the game-logic reset/strobe line: static level plus a
// hardware-timed pulse of programmable length with an optional completion interrupt.
module nios_system_rst_out #(
  parameter int unsigned          PULSE_W     = 16,
  parameter logic [PULSE_W-1:0]   DEFAULT_LEN = PULSE_W'(50),
  parameter logic                 RESET_VALUE = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        out_port,
  output logic        irq
);

  typedef enum logic [0:0] {StIdle, StPulse} state_e;

  state_e             state_q, state_d;
  logic [PULSE_W-1:0] count_q, count_d;
  logic [PULSE_W-1:0] len_q, len_d;
  logic               data_q, data_d;
  logic               irq_en_q, irq_en_d;
  logic               irq_pend_q, irq_pend_d;
  logic [31:0]        readdata_q, readdata_d;

  logic wr, wr_data, wr_len, wr_ctrl, wr_count;
  logic start, abort, busy, pulse_end;

  assign wr       = chipselect & ~write_n;
  assign wr_data  = wr & (address == 2'd0);
  assign wr_len   = wr & (address == 2'd1);
  assign wr_ctrl  = wr & (address == 2'd2);
  assign wr_count = wr & (address == 2'd3);
  assign start    = wr_ctrl & writedata[0];
  assign abort    = wr_ctrl & writedata[1];
  assign busy     = (state_q == StPulse);

  // Pulse FSM; abort takes priority over start and over natural completion.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    pulse_end = 1'b0;
    if (abort) begin
      state_d = StIdle;
      count_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start && (len_q != '0)) begin
            state_d = StPulse;
            count_d = len_q;
          end
        end
        StPulse: begin
          if (start && (len_q != '0)) begin
            count_d = len_q;
          end else if (count_q > PULSE_W'(1)) begin
            count_d = count_q - PULSE_W'(1);
          end else begin
            state_d   = StIdle;
            count_d   = '0;
            pulse_end = 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
          count_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    data_d     = wr_data ? writedata[0] : data_q;
    len_d      = wr_len ? writedata[PULSE_W-1:0] : len_q;
    irq_en_d   = wr_ctrl ? writedata[2] : irq_en_q;
    // Completion set beats a software clear on the same edge.
    irq_pend_d = pulse_end ? 1'b1 : (wr_count ? 1'b0 : irq_pend_q);
  end

  // Read mux is sampled every edge regardless of chipselect.
  always_comb begin
    readdata_d = '0;
    unique case (address)
      2'd0: readdata_d[0]           = data_q;
      2'd1: readdata_d[PULSE_W-1:0] = len_q;
      2'd2: readdata_d[2:0]         = {irq_en_q, irq_pend_q, busy};
      2'd3: readdata_d[PULSE_W-1:0] = count_q;
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      count_q    <= '0;
      len_q      <= DEFAULT_LEN;
      data_q     <= RESET_VALUE;
      irq_en_q   <= 1'b0;
      irq_pend_q <= 1'b0;
      readdata_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      len_q      <= len_d;
      data_q     <= data_d;
      irq_en_q   <= irq_en_d;
      irq_pend_q <= irq_pend_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign out_port = data_q | busy;
  assign irq      = irq_pend_q & irq_en_q;

endmodule

// File: tb/tb_nios_system_rst_out.sv
// Scoreboard bench for nios_system_rst_out: a pulse-deadline reference model predicts
// out_port/irq/readdata per edge; a monitor compares one edge later.
module tb_nios_system_rst_out;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        out_port;
  logic        irq;

  always #5 clk = ~clk;

  nios_system_rst_out dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .irq        (irq)
  );

  typedef struct packed {
    logic        op;
    logic        irq;
    logic [31:0] rd;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: the pulse is a deadline m_end; it is active while now < m_end.
  int unsigned now;
  int unsigned m_end;
  bit          m_data;
  int unsigned m_len;
  bit          m_en;
  bit          m_pend;

  task automatic model_reset();
    now = 0; m_end = 0; m_data = 1'b0; m_len = 50; m_en = 1'b0; m_pend = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // One bus cycle: drive at negedge, predict the state after the following posedge.
  task automatic bus(input bit wr, input logic [1:0] a, input logic [31:0] wd);
    bit          busy_prev, start, abort, reload, ends;
    int unsigned n;
    logic [31:0] rd;
    @(negedge clk);
    address   = a;
    writedata = wd;
    if (wr) begin
      chipselect = 1'b1; write_n = 1'b0;
    end else if ($urandom_range(0, 1) == 1) begin
      chipselect = 1'b0; write_n = 1'($urandom_range(0, 1));
    end else begin
      chipselect = 1'b1; write_n = 1'b1;
    end
    n         = now + 1;
    busy_prev = now < m_end;
    case (a)
      2'd0:    rd = {31'd0, m_data};
      2'd1:    rd = m_len;
      2'd2:    rd = {29'd0, m_en, m_pend, busy_prev};
      default: rd = busy_prev ? (m_end - now) : 32'd0;
    endcase
    start  = wr && (a == 2'd2) && wd[0];
    abort  = wr && (a == 2'd2) && wd[1];
    reload = start && !abort && (m_len != 0);
    ends   = busy_prev && (n == m_end) && !abort && !reload;
    if (wr) begin
      case (a)
        2'd0:    m_data = wd[0];
        2'd1:    m_len  = wd[15:0];
        2'd2:    m_en   = wd[2];
        default: m_pend = 1'b0;
      endcase
    end
    if (abort) m_end = 0;
    else if (reload) m_end = n + m_len;
    if (ends) m_pend = 1'b1;
    now = n;
    exp_q.push_back('{op: m_data | (now < m_end), irq: m_pend & m_en, rd: rd});
  endtask

  task automatic rd_cyc(input logic [1:0] a, input int cycles);
    for (int i = 0; i < cycles; i++) bus(1'b0, a, $urandom);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("out_port", {31'd0, out_port}, {31'd0, e.op});
      check("irq", {31'd0, irq}, {31'd0, e.irq});
      check("readdata", readdata, e.rd);
    end
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_out_port", {31'd0, out_port}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_readdata", readdata, 32'd0);
    reset_n = 1'b1;

    // Reset register values
    rd_cyc(2'd0, 1); rd_cyc(2'd1, 1); rd_cyc(2'd2, 1); rd_cyc(2'd3, 1);

    // Static level
    bus(1'b1, 2'd0, 32'd1); rd_cyc(2'd0, 2);
    bus(1'b1, 2'd0, 32'hFFFF_FFFE); rd_cyc(2'd0, 2);

    // Timed pulse with irq, then clear
    bus(1'b1, 2'd1, 32'hABCD_0005); bus(1'b1, 2'd2, 32'd5);
    rd_cyc(2'd3, 7); rd_cyc(2'd2, 2);
    bus(1'b1, 2'd3, $urandom); rd_cyc(2'd2, 2);

    // Retrigger then zero-length start
    bus(1'b1, 2'd1, 32'd10); bus(1'b1, 2'd2, 32'd5);
    rd_cyc(2'd3, 3); bus(1'b1, 2'd2, 32'd5);
    rd_cyc(2'd3, 16); bus(1'b1, 2'd3, 32'd0);
    bus(1'b1, 2'd1, 32'd0); bus(1'b1, 2'd2, 32'd5); rd_cyc(2'd2, 4);

    // Abort, start+abort, clear colliding with pulse end
    bus(1'b1, 2'd1, 32'd8); bus(1'b1, 2'd2, 32'd5);
    rd_cyc(2'd3, 2); bus(1'b1, 2'd2, 32'd6); rd_cyc(2'd2, 3);
    bus(1'b1, 2'd2, 32'd7); rd_cyc(2'd2, 3);
    bus(1'b1, 2'd1, 32'd3); bus(1'b1, 2'd2, 32'd5);
    rd_cyc(2'd3, 2); bus(1'b1, 2'd3, 32'd0); rd_cyc(2'd2, 2);
    bus(1'b1, 2'd3, 32'd0);

    // Randomised traffic, short pulse lengths so completions happen often
    for (int i = 0; i < 400; i++) begin
      logic [1:0]  a;
      logic [31:0] wd;
      a  = 2'($urandom_range(0, 3));
      wd = $urandom;
      if (a == 2'd1) wd[15:0] = 16'($urandom_range(0, 9));
      if (a == 2'd2 && $urandom_range(0, 3) != 0) wd[1] = 1'b0;
      bus($urandom_range(0, 3) == 0, a, wd);
    end

    // Reset in the middle of a long pulse
    bus(1'b1, 2'd1, 32'd100); bus(1'b1, 2'd2, 32'd1);
    rd_cyc(2'd3, 19);
    @(negedge clk);
    exp_q.delete();
    reset_n = 1'b0;
    #1;
    check("midrst_out_port", {31'd0, out_port}, 32'd0);
    check("midrst_irq", {31'd0, irq}, 32'd0);
    check("midrst_readdata", readdata, 32'd0);
    repeat (2) @(negedge clk);
    model_reset();
    reset_n = 1'b1;
    rd_cyc(2'd2, 1); rd_cyc(2'd1, 1); rd_cyc(2'd0, 2);

    @(posedge clk);
    #2;
    if (exp_q.size() != 0) check("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
